// File: rtl/wptr_ctrl_sync.sv
// wptr_ctrl_sync: write-domain FIFO controller with read-pointer sync, flags, level and sticky overflow
module wptr_ctrl_sync #(
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH-2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  wclk,
  input  logic                  wrstn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   g_rptr,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH:0]   b_wptr,
  output logic [ADDR_WIDTH:0]   g_wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = PW'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF    = PW'(AFULL_THRESH);
  logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] sync_q;
  logic [ADDR_WIDTH:0] g_rptr_s, b_rptr_s;
  logic [ADDR_WIDTH:0] b_wptr_q, b_wptr_d, g_wptr_q, g_wptr_d, level_q, level_d;
  logic full_q, full_d, af_q, af_d, ovf_q, ovf_d;
  assign g_rptr_s = sync_q[SYNC_STAGES-1];
  // each binary bit is the XOR of all Gray bits at or above it
  for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_g2b
    assign b_rptr_s[i] = ^g_rptr_s[ADDR_WIDTH:i];
  end
  always_comb begin
    wr_accept = wr_en & ~full_q;
    b_wptr_d  = b_wptr_q + PW'(wr_accept);
    g_wptr_d  = b_wptr_d ^ (b_wptr_d >> 1);
    level_d   = b_wptr_d - b_rptr_s;
    full_d    = level_d == DEPTH;
    af_d      = level_d >= AF;
    ovf_d     = (wr_en & full_q) | (ovf_q & ~ovf_clr);
  end
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      sync_q   <= '0;
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], g_rptr};
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= g_wptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end
  assign waddr       = b_wptr_q[ADDR_WIDTH-1:0];
  assign b_wptr      = b_wptr_q;
  assign g_wptr      = g_wptr_q;
  assign wr_level    = level_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_wptr_ctrl_sync.sv
// tb_wptr_ctrl_sync: directed vector table plus random soak against a count-based FIFO model
module tb_wptr_ctrl_sync;
  logic wclk = 1'b0, rclk = 1'b0;
  logic wrstn, wr_en, ovf_clr, soak_on = 1'b0;
  logic [3:0] g_rptr, g_drv, g_rd = 4'd0;
  logic [2:0] waddr;
  logic wr_accept, full, almost_full, overflow;
  logic [3:0] b_wptr, g_wptr, wr_level;
  int n_chk = 0, n_fail = 0, wr_cnt = 0, rd_cnt = 0;
  logic prev_full;
  logic [3:0] s1, s2, used, last_g = 4'd0;

  assign g_rptr = soak_on ? g_rd : g_drv;

  wptr_ctrl_sync #(.ADDR_WIDTH(3), .AFULL_THRESH(6), .SYNC_STAGES(2)) dut (
    .wclk(wclk), .wrstn(wrstn), .wr_en(wr_en), .g_rptr(g_rptr), .ovf_clr(ovf_clr),
    .waddr(waddr), .wr_accept(wr_accept), .b_wptr(b_wptr), .g_wptr(g_wptr),
    .full(full), .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  always #5 wclk = ~wclk;
  initial begin
    #2;
    forever #7 rclk = ~rclk;
  end

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".b_wptr"}, b_wptr, 0);
    chk({tag, ".g_wptr"}, g_wptr, 0);
    chk({tag, ".waddr"}, waddr, 0);
    chk({tag, ".wr_level"}, wr_level, 0);
    chk({tag, ".full"}, full, 0);
    chk({tag, ".almost_full"}, almost_full, 0);
    chk({tag, ".overflow"}, overflow, 0);
  endtask

  // reference sync chain: which read pointer the DUT used at the last edge
  always @(posedge wclk or negedge wrstn)
    if (!wrstn) begin
      s1 <= '0; s2 <= '0; used <= '0;
    end else begin
      used <= s2; s2 <= s1; s1 <= g_rptr;
    end

  always @(negedge wclk) begin
    if (wrstn) begin
      chk("gray_full_xcheck", full, int'(g_wptr == {~used[3:2], used[1:0]}));
      chk("gray_one_bit_step", int'($countones(g_wptr ^ last_g) <= 1), 1);
    end
    last_g <= g_wptr;
  end

  // soak model: true stored count = accepted writes - reads
  always @(posedge wclk)
    if (!soak_on) wr_cnt <= 0;
    else if (wr_accept) begin
      chk("no_accept_when_8_stored", int'(wr_cnt - rd_cnt < 8), 1);
      wr_cnt <= wr_cnt + 1;
    end

  always @(posedge rclk)
    if (!soak_on) begin
      rd_cnt <= 0; g_rd <= '0;
    end else if (wr_cnt - rd_cnt > 0 && $urandom_range(0, 1) == 1) begin
      rd_cnt <= rd_cnt + 1;
      g_rd   <= gray(rd_cnt + 1);
    end

  typedef struct {
    logic       we;
    logic [3:0] gr;
    logic       clr;
    int         lvl;
    logic       fu;
    logic       af;
    int         bw;
    logic       ov;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic we, input logic [3:0] gr, input logic clr, input int lvl,
                     input logic fu, input logic af, input int bw, input logic ov);
    vec_t v;
    v.we = we; v.gr = gr; v.clr = clr; v.lvl = lvl; v.fu = fu; v.af = af; v.bw = bw; v.ov = ov;
    tbl.push_back(v);
  endtask

  initial begin
    for (int k = 1; k <= 8; k++) add(1, 4'b0000, 0, k, k == 8, k >= 6, k, 0);
    add(1, 4'b0000, 0, 8, 1, 1, 8, 1);
    add(0, 4'b0000, 1, 8, 1, 1, 8, 0);
    add(1, 4'b0000, 1, 8, 1, 1, 8, 1);
    add(1, 4'b0000, 1, 8, 1, 1, 8, 1);
    add(0, 4'b0000, 1, 8, 1, 1, 8, 0);
    add(0, 4'b0011, 0, 8, 1, 1, 8, 0);
    add(0, 4'b0011, 0, 8, 1, 1, 8, 0);
    add(0, 4'b0011, 0, 6, 0, 1, 8, 0);
    add(0, 4'b1100, 0, 6, 0, 1, 8, 0);
    add(0, 4'b1100, 0, 6, 0, 1, 8, 0);
    add(0, 4'b1100, 0, 0, 0, 0, 8, 0);
    for (int k = 1; k <= 7; k++) add(1, 4'b1100, 0, k, 0, k >= 6, 8 + k, 0);
    add(1, 4'b1100, 0, 8, 1, 1, 0, 0);

    wrstn = 1'b0; wr_en = 1'b0; g_drv = '0; ovf_clr = 1'b0;
    repeat (2) @(posedge wclk);
    #1 wrstn = 1'b1;
    repeat (2) begin
      @(posedge wclk); #1;
      chk_zero("post_reset_idle");
    end
    wr_en = 1'b1;
    repeat (3) @(posedge wclk);
    #1 chk("pre_reset_b_wptr", b_wptr, 3);
    #2 wrstn = 1'b0; wr_en = 1'b0;
    #1 chk_zero("async_reset");
    @(posedge wclk); #1 wrstn = 1'b1;
    @(posedge wclk); #1 chk_zero("after_reset_release");

    prev_full = 1'b0;
    foreach (tbl[r]) begin
      wr_en = tbl[r].we; g_drv = tbl[r].gr; ovf_clr = tbl[r].clr;
      #1 chk($sformatf("row%0d.wr_accept", r), wr_accept, int'(tbl[r].we && !prev_full));
      @(posedge wclk); #1;
      chk($sformatf("row%0d.wr_level", r), wr_level, tbl[r].lvl);
      chk($sformatf("row%0d.full", r), full, tbl[r].fu);
      chk($sformatf("row%0d.almost_full", r), almost_full, tbl[r].af);
      chk($sformatf("row%0d.b_wptr", r), b_wptr, tbl[r].bw % 16);
      chk($sformatf("row%0d.g_wptr", r), g_wptr, gray(tbl[r].bw));
      chk($sformatf("row%0d.waddr", r), waddr, tbl[r].bw % 8);
      chk($sformatf("row%0d.overflow", r), overflow, tbl[r].ov);
      prev_full = tbl[r].fu;
    end
    chk("wrap_g_wptr_zero", g_wptr, 0);

    wr_en = 1'b0; ovf_clr = 1'b0; g_drv = '0; wrstn = 1'b0;
    repeat (2) @(posedge wclk);
    #1 wrstn = 1'b1; soak_on = 1'b1;
    repeat (2000) begin
      @(posedge wclk); #1;
      wr_en   = $urandom_range(0, 3) != 0;
      ovf_clr = $urandom_range(0, 7) == 0;
      @(negedge wclk);
      chk("level_ge_true_count", int'(int'(wr_level) >= wr_cnt - rd_cnt), 1);
    end
    wr_en = 1'b0;
    @(posedge wclk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
